sig_cond: RTL and testbench
===========================

SIG_COND -- requirements
Module: sig_cond

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchronizer flops (legal 2..4).
REQ-002 Parameter CNT_W, default 16, width of the glitch counter.
REQ-003 clk_i  input  1  system clock; one clock domain, all logic on its rising edge.
REQ-004 rst_i  input  1  reset; synchronous, active-high.
REQ-005 sig_i  input  1  raw measured signal, asynchronous to clk_i; feeds the measure stage after conditioning.
REQ-006 en_i  input  1  conditioning enable.
REQ-007 filt_len_i  input  4  number of extra stable cycles required to accept a transition.
REQ-008 clr_i  input  1  one-cycle pulse that clears glitch_cnt_o.
REQ-009 sig_o  output  1  filtered, synchronized signal level.
REQ-010 rise_o  output  1  one-cycle pulse on each accepted rising transition.
REQ-011 fall_o  output  1  one-cycle pulse on each accepted falling transition.
REQ-012 glitch_cnt_o  output  CNT_W  saturating count of rejected transitions.

Function
REQ-013 sig_i SHALL pass through a SYNC_STAGES-deep flop chain; the last stage is "s".
REQ-014 The FSM SHALL have the states LOW, RISE_CHK, HIGH and FALL_CHK.
REQ-015 LOW: s=1 and en_i=1 -> RISE_CHK, cnt=0 and filt_len_i latched into len; otherwise stay.
REQ-016 RISE_CHK: s=0 -> LOW and a glitch is counted; else cnt==len -> HIGH and rise_o=1; else cnt+1.
REQ-017 HIGH and FALL_CHK SHALL mirror LOW and RISE_CHK with polarity inverted and fall_o in place of rise_o.
REQ-018 filt_len_i changes SHALL NOT affect a check already in progress; only the latched len applies.
REQ-019 sig_o SHALL be 1 exactly in HIGH and FALL_CHK.
REQ-020 rise_o, fall_o and sig_o SHALL all be registered.
REQ-021 Latency: sig_o and the pulse SHALL change on the clock edge SYNC_STAGES+len+1 after the edge that first captures the new level.
REQ-022 A pulse of s shorter than len+1 cycles SHALL produce no edge pulse and SHALL increment glitch_cnt_o by 1.
REQ-023 rise_o and fall_o SHALL never be high in the same cycle.
REQ-024 Each pulse SHALL be exactly one cycle wide.
REQ-025 en_i=0 in a check state SHALL return the FSM to the prior stable state with no pulse and no glitch count.
REQ-026 en_i=0 in a stable state SHALL hold that state.
REQ-027 glitch_cnt_o SHALL saturate at all-ones and SHALL NOT wrap.
REQ-028 When clr_i and a glitch coincide, clr_i SHALL win and the result is 0.
REQ-029 filt_len_i=0 SHALL accept a level that is stable for 1 cycle in the check state.
REQ-030 filt_len_i=15 SHALL require 16 stable cycles.

Reset
REQ-031 While rst_i is high, at each edge: sync flops=0, state=LOW, cnt=0, len=0, sig_o=0, rise_o=0, fall_o=0, glitch_cnt_o=0.
REQ-032 A reset asserted mid-check SHALL abort the check with no pulse emitted.
REQ-033 If sig_i is high at reset release, a single rise_o SHALL follow after the normal latency.

Structure
REQ-034 Shared package dfm_pkg SHALL hold the state enum type (sig_cond_state_t) and the defaults SYNC_STAGES_DEF=2 and CNT_W_DEF=16.
REQ-035 The synchronizer SHALL be a separate sub-module, sig_sync (parameter STAGES, ports clk_i, rst_i, d_i, q_o).
REQ-036 sig_cond SHALL instantiate exactly one sig_sync.
REQ-037 The RTL SHALL contain no latches, no clocking on sig_i, and no combinational path from sig_i to any output.

Verification
REQ-038 Clean edge: filt_len_i=3, sig_i 0->1 held for 20 cycles -> rise_o one cycle at capture edge +6, sig_o=1 from then, glitch_cnt_o=0.
REQ-039 Glitch: filt_len_i=3, sig_i high for 2 cycles -> no rise_o, sig_o stays 0, glitch_cnt_o=1.
REQ-040 Square wave: 500 ns period on a 5 ns clock, filt_len_i=0 -> rise_o and fall_o alternate, each spaced 50 cycles, with no double pulses.
REQ-041 Saturation and clear: CNT_W=4, 20 glitches -> glitch_cnt_o=15; clr_i coincident with glitch 21 -> 0.
REQ-042 Disable: en_i dropped during RISE_CHK -> state LOW, no rise_o; en_i restored with sig_i still high -> normal rise_o after latency.
REQ-043 Reset mid-check: rst_i asserted 2 cycles into FALL_CHK -> all outputs 0 next edge, no fall_o; after release, sig_i high -> one rise_o.

Source files
------------

// File: rtl/dfm_pkg.sv
// Shared types and defaults for the signal-conditioning front end.
// Holds the conditioner state encoding and the parameter defaults.
package dfm_pkg;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int CNT_W_DEF       = 16;

  typedef enum logic [1:0] {
    ST_LOW      = 2'd0,
    ST_RISE_CHK = 2'd1,
    ST_HIGH     = 2'd2,
    ST_FALL_CHK = 2'd3
  } sig_cond_state_t;

endpackage

// File: rtl/sig_sync.sv
// Multi-flop synchronizer bringing an asynchronous level into clk_i; latency STAGES edges.
// No flow control: samples every cycle, cleared to 0 by reset.
module sig_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/sig_cond.sv
// Synchronizes and debounces sig_i, emitting edge pulses and a saturating glitch count.
// Latency SYNC_STAGES+len+1 edges from capture to sig_o/pulse; no backpressure, one decision per cycle.
module sig_cond
  import dfm_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             sig_i,
  input  logic             en_i,
  input  logic [3:0]       filt_len_i,
  input  logic             clr_i,
  output logic             sig_o,
  output logic             rise_o,
  output logic             fall_o,
  output logic [CNT_W-1:0] glitch_cnt_o
);

  localparam logic [CNT_W-1:0] GLITCH_MAX = '1;
  localparam logic [CNT_W-1:0] GLITCH_ONE = CNT_W'(1);

  logic            s;
  sig_cond_state_t state;
  logic [3:0]      cnt;
  logic [3:0]      len;
  logic            glitch;

  sig_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .d_i  (sig_i),
    .q_o  (s)
  );

  // A disabled check is abandoned quietly, so en_i gates the glitch event.
  always_comb begin
    glitch = en_i && (((state == ST_RISE_CHK) && !s) ||
                      ((state == ST_FALL_CHK) &&  s));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= ST_LOW;
      cnt    <= '0;
      len    <= '0;
      sig_o  <= 1'b0;
      rise_o <= 1'b0;
      fall_o <= 1'b0;
    end else begin
      rise_o <= 1'b0;
      fall_o <= 1'b0;
      case (state)
        ST_LOW: begin
          if (s && en_i) begin
            state <= ST_RISE_CHK;
            cnt   <= '0;
            len   <= filt_len_i;
          end
        end
        ST_RISE_CHK: begin
          if (!en_i || !s) begin
            state <= ST_LOW;
          end else if (cnt == len) begin
            state  <= ST_HIGH;
            sig_o  <= 1'b1;
            rise_o <= 1'b1;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ST_HIGH: begin
          if (!s && en_i) begin
            state <= ST_FALL_CHK;
            cnt   <= '0;
            len   <= filt_len_i;
          end
        end
        ST_FALL_CHK: begin
          if (!en_i || s) begin
            state <= ST_HIGH;
          end else if (cnt == len) begin
            state  <= ST_LOW;
            sig_o  <= 1'b0;
            fall_o <= 1'b1;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: begin
          state <= ST_LOW;
          sig_o <= 1'b0;
        end
      endcase
    end
  end

  // Clear takes priority over a coincident glitch; the count sticks at all-ones.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      glitch_cnt_o <= '0;
    end else if (glitch && (glitch_cnt_o != GLITCH_MAX)) begin
      glitch_cnt_o <= glitch_cnt_o + GLITCH_ONE;
    end
  end

endmodule

// File: tb/tb_sig_cond.sv
// Bench for sig_cond: vector table, directed corner sequences and a random run
// compared each cycle against a run-length reference model.
module tb_sig_cond;

  localparam int STAGES = 2;
  localparam int CW     = 4;
  localparam int GMAX   = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          sig;
  logic          en;
  logic [3:0]    flen;
  logic          clr;
  logic          sig_o;
  logic          rise_o;
  logic          fall_o;
  logic [CW-1:0] gcnt;

  always #5 clk = ~clk;

  sig_cond #(
    .SYNC_STAGES(STAGES),
    .CNT_W      (CW)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .sig_i       (sig),
    .en_i        (en),
    .filt_len_i  (flen),
    .clr_i       (clr),
    .sig_o       (sig_o),
    .rise_o      (rise_o),
    .fall_o      (fall_o),
    .glitch_cnt_o(gcnt)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int n_rise = 0;
  int n_fall = 0;

  // Reference model: accepted level plus the number of consecutive differing samples seen.
  bit sh[STAGES];
  bit m_lvl;
  int m_run;
  int m_len;
  bit m_rise;
  bit m_fall;
  int m_gcnt;

  typedef struct {
    int len;
    int hi;
    int exp_rise;
    int exp_glitch;
    int exp_lat;
  } vec_t;

  vec_t vt[8];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_step();
    bit s;
    bit g;
    if (rst) begin
      foreach (sh[k]) sh[k] = 1'b0;
      m_lvl  = 1'b0;
      m_run  = 0;
      m_len  = 0;
      m_rise = 1'b0;
      m_fall = 1'b0;
      m_gcnt = 0;
      return;
    end
    s      = sh[STAGES-1];
    g      = 1'b0;
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (m_run == 0) begin
      if (en && (s != m_lvl)) begin
        m_run = 1;
        m_len = int'(flen);
      end
    end else if (!en) begin
      m_run = 0;
    end else if (s == m_lvl) begin
      m_run = 0;
      g     = 1'b1;
    end else if (m_run == m_len + 1) begin
      m_lvl = s;
      m_run = 0;
      if (s) m_rise = 1'b1;
      else   m_fall = 1'b1;
    end else begin
      m_run++;
    end
    if (clr) m_gcnt = 0;
    else if (g && (m_gcnt < GMAX)) m_gcnt++;
    for (int k = STAGES - 1; k > 0; k--) sh[k] = sh[k-1];
    sh[0] = sig;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    check("sig_o",          int'(sig_o),  int'(m_lvl));
    check("rise_o",         int'(rise_o), int'(m_rise));
    check("fall_o",         int'(fall_o), int'(m_fall));
    check("glitch_cnt",     int'(gcnt),   m_gcnt);
    check("rise_fall_excl", int'(rise_o & fall_o), 0);
    if (rise_o) n_rise++;
    if (fall_o) n_fall++;
  endtask

  task automatic clear_cnt();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    int lat;
    int last_ev;
    int last_t;
    int n_ev;
    int seg;

    vt[0] = '{len: 3,  hi: 20, exp_rise: 1, exp_glitch: 0, exp_lat: 6};
    vt[1] = '{len: 3,  hi: 2,  exp_rise: 0, exp_glitch: 1, exp_lat: -1};
    vt[2] = '{len: 0,  hi: 2,  exp_rise: 1, exp_glitch: 0, exp_lat: 3};
    vt[3] = '{len: 1,  hi: 3,  exp_rise: 1, exp_glitch: 0, exp_lat: 4};
    vt[4] = '{len: 15, hi: 17, exp_rise: 1, exp_glitch: 0, exp_lat: 18};
    vt[5] = '{len: 15, hi: 15, exp_rise: 0, exp_glitch: 1, exp_lat: -1};
    vt[6] = '{len: 7,  hi: 30, exp_rise: 1, exp_glitch: 0, exp_lat: 10};
    vt[7] = '{len: 7,  hi: 5,  exp_rise: 0, exp_glitch: 1, exp_lat: -1};

    rst = 1'b1; sig = 1'b0; en = 1'b1; flen = 4'd0; clr = 1'b0;
    repeat (3) tick();
    check("reset_sig_o",  int'(sig_o),  0);
    check("reset_rise_o", int'(rise_o), 0);
    check("reset_fall_o", int'(fall_o), 0);
    check("reset_gcnt",   int'(gcnt),   0);
    rst = 1'b0;
    repeat (5) tick();

    // Table: pulse of hi cycles from idle low, then a long low tail.
    for (int v = 0; v < 8; v++) begin
      clear_cnt();
      flen   = 4'(vt[v].len);
      n_rise = 0;
      n_fall = 0;
      lat    = -1;
      sig    = 1'b1;
      for (int t = 0; t < vt[v].hi + 40; t++) begin
        if (t == vt[v].hi) sig = 1'b0;
        tick();
        if (rise_o && (lat < 0)) lat = t;
      end
      check($sformatf("vec%0d_rises", v),   n_rise,      vt[v].exp_rise);
      check($sformatf("vec%0d_falls", v),   n_fall,      vt[v].exp_rise);
      check($sformatf("vec%0d_glitch", v),  int'(gcnt),  vt[v].exp_glitch);
      check($sformatf("vec%0d_latency", v), lat,         vt[v].exp_lat);
      check($sformatf("vec%0d_final", v),   int'(sig_o), 0);
    end

    // Saturation, then clear coincident with the 21st glitch.
    clear_cnt();
    flen = 4'd3;
    repeat (20) begin
      sig = 1'b1; repeat (2) tick();
      sig = 1'b0; repeat (8) tick();
    end
    check("sat_gcnt", int'(gcnt), GMAX);
    sig = 1'b1; repeat (2) tick();
    sig = 1'b0; repeat (2) tick();
    clr = 1'b1; tick(); clr = 1'b0;
    check("clr_wins_gcnt", int'(gcnt), 0);
    repeat (6) tick();
    sig = 1'b1; repeat (2) tick();
    sig = 1'b0; repeat (8) tick();
    check("after_clr_gcnt", int'(gcnt), 1);

    // Square wave, 100-cycle period, zero filter length.
    clear_cnt();
    flen    = 4'd0;
    last_ev = 0;
    last_t  = -1;
    n_ev    = 0;
    for (int t = 0; t < 400; t++) begin
      sig = ((t % 100) < 50);
      tick();
      if (rise_o || fall_o) begin
        if (n_ev > 0) begin
          check("sq_alternate", int'(rise_o), (last_ev == 2) ? 1 : 0);
          check("sq_spacing",   t - last_t, 50);
        end
        last_ev = rise_o ? 1 : 2;
        last_t  = t;
        n_ev++;
      end
    end
    check("sq_events", n_ev, 8);
    check("sq_glitch", int'(gcnt), 0);

    // Enable dropped mid rise-check, then restored with the input still high.
    clear_cnt();
    flen   = 4'd3;
    n_rise = 0;
    sig    = 1'b1;
    repeat (4) tick();
    en = 1'b0;
    repeat (5) tick();
    check("dis_sig_o", int'(sig_o), 0);
    check("dis_rises", n_rise, 0);
    en = 1'b1;
    repeat (10) tick();
    check("dis_rise_after", n_rise, 1);
    check("dis_gcnt",       int'(gcnt), 0);
    sig = 1'b0;
    repeat (20) tick();

    // Reset two cycles into a fall check, input high across release.
    flen = 4'd3;
    sig  = 1'b1;
    repeat (10) tick();
    check("rst_pre_high", int'(sig_o), 1);
    n_fall = 0;
    sig    = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    sig = 1'b1;
    tick();
    check("rst_mid_sig_o",  int'(sig_o),  0);
    check("rst_mid_rise_o", int'(rise_o), 0);
    check("rst_mid_fall_o", int'(fall_o), 0);
    check("rst_mid_gcnt",   int'(gcnt),   0);
    tick();
    rst    = 1'b0;
    n_rise = 0;
    lat    = -1;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (rise_o && (lat < 0)) lat = t;
    end
    check("rst_no_fall",     n_fall, 0);
    check("rst_one_rise",    n_rise, 1);
    check("rst_rise_latency", lat, 6);

    // Random run-length stimulus against the model.
    for (seg = 0; seg < 300; seg++) begin
      sig = ~sig;
      if ($urandom_range(0, 3) == 0) flen = 4'($urandom_range(0, 15));
      en  = ($urandom_range(0, 9) != 0);
      clr = ($urandom_range(0, 29) == 0);
      rst = ($urandom_range(0, 149) == 0);
      for (int j = 0; j < $urandom_range(1, 22); j++) begin
        tick();
        clr = 1'b0;
        rst = 1'b0;
        if ($urandom_range(0, 15) == 0) en = ~en;
      end
      en = 1'b1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
